// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display path,
// used by the scan controller and the upstream segment-data mux.
package display_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;
  localparam int DEFAULT_DWELL_W    = 8;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_SHOW  = 2'd1,
    SCAN_BLANK = 2'd2
  } scan_state_e;

  // Digit 0 drives the most significant CAT bit.
  localparam bit CAT_DIGIT0_MSB = 1'b1;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control/status bundle between the display front end and the scan controller.
interface display_scan_ctrl_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int DWELL_W    = DEFAULT_DWELL_W
);

  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic                  enable;
  logic [DWELL_W-1:0]    dwell;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [SEL_W-1:0]      SEL;
  logic [NUM_DIGITS-1:0] CAT;
  logic                  blank;
  logic                  frame_start;

  modport master (
    output enable, dwell, digit_en,
    input  SEL, CAT, blank, frame_start
  );

  modport slave (
    input  enable, dwell, digit_en,
    output SEL, CAT, blank, frame_start
  );

endinterface

// File: rtl/next_digit_sel.sv
// Rotated priority search: next set bit of digit_en strictly above sel,
// wrapping through index 0; wrapped flags a landing at or below sel.
module next_digit_sel #(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]      next_sel,
  output logic                  wrapped
);

  logic found;

  always_comb begin
    int idx;
    idx      = 0;
    next_sel = sel;
    wrapped  = 1'b1;
    found    = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      idx = (int'(sel) + k) % NUM_DIGITS;
      if (!found && digit_en[SEL_W'(idx)]) begin
        found    = 1'b1;
        next_sel = SEL_W'(idx);
        wrapped  = (idx <= int'(sel));
      end
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan sequencer for an N-digit multiplexed 7-segment display with
// per-digit dwell, optional blanking between digits and a frame strobe.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int DWELL_W      = DEFAULT_DWELL_W,
  parameter int BLANK_CYCLES = 1
) (
  input logic                slow_clock,
  input logic                reset,
  display_scan_ctrl_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_DIGITS);

  localparam logic [1:0] ST_IDLE  = SCAN_IDLE;
  localparam logic [1:0] ST_SHOW  = SCAN_SHOW;
  localparam logic [1:0] ST_BLANK = SCAN_BLANK;

  localparam logic [DWELL_W-1:0]    BLANK_LAST = DWELL_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0]      LAST_IDX   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] CAT_ORIGIN = CAT_DIGIT0_MSB ?
                                                 {1'b1, {(NUM_DIGITS-1){1'b0}}} :
                                                 {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [SEL_W-1:0] s);
    return CAT_DIGIT0_MSB ? (CAT_ORIGIN >> s) : (CAT_ORIGIN << s);
  endfunction

  logic [1:0]            state;
  logic [SEL_W-1:0]      sel_q;
  logic [NUM_DIGITS-1:0] cat_q;
  logic                  blank_q;
  logic                  frame_q;
  logic [DWELL_W-1:0]    cnt;
  logic [DWELL_W-1:0]    dwell_q;

  logic [SEL_W-1:0]      adv_sel;
  logic                  adv_wrap;
  logic [SEL_W-1:0]      first_sel;
  logic                  first_wrap;
  logic                  any_en;
  logic                  digit_done;
  logic                  blank_done;
  logic                  do_start;
  logic                  do_adv;
  logic [SEL_W-1:0]      tgt_sel;
  logic                  tgt_frame;

  next_digit_sel #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_adv (
    .sel      (sel_q),
    .digit_en (bus.digit_en),
    .next_sel (adv_sel),
    .wrapped  (adv_wrap)
  );

  // Searching above the top index always wraps, yielding the lowest enabled digit.
  next_digit_sel #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_first (
    .sel      (LAST_IDX),
    .digit_en (bus.digit_en),
    .next_sel (first_sel),
    .wrapped  (first_wrap)
  );

  always_comb begin
    any_en     = |bus.digit_en;
    digit_done = (state == ST_SHOW) && (cnt == dwell_q);
    blank_done = (state == ST_BLANK) && (cnt == BLANK_LAST);
    do_start   = (state == ST_IDLE) && any_en;
    do_adv     = (digit_done && (BLANK_CYCLES == 0)) || blank_done;
    tgt_sel    = do_start ? first_sel : adv_sel;
    tgt_frame  = do_start ? first_wrap : adv_wrap;
  end

  always_ff @(negedge slow_clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      sel_q   <= '0;
      cat_q   <= '0;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
      cnt     <= '0;
      dwell_q <= '0;
    end else if (!bus.enable) begin
      state   <= ST_IDLE;
      cat_q   <= '0;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
      cnt     <= '0;
    end else if (do_start || (do_adv && any_en)) begin
      state   <= ST_SHOW;
      sel_q   <= tgt_sel;
      cat_q   <= digit_onehot(tgt_sel);
      blank_q <= 1'b0;
      frame_q <= tgt_frame;
      cnt     <= '0;
      dwell_q <= bus.dwell;
    end else if (do_adv) begin
      state   <= ST_IDLE;
      cat_q   <= '0;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
      cnt     <= '0;
    end else if (digit_done) begin
      state   <= ST_BLANK;
      cat_q   <= '0;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
      cnt     <= '0;
    end else if (state == ST_SHOW) begin
      // A digit dropped from the mask mid-dwell goes dark but keeps its time slot.
      cnt     <= cnt + DWELL_W'(1);
      cat_q   <= bus.digit_en[sel_q] ? digit_onehot(sel_q) : '0;
      blank_q <= ~bus.digit_en[sel_q];
      frame_q <= 1'b0;
    end else if (state == ST_BLANK) begin
      cnt     <= cnt + DWELL_W'(1);
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
    end
  end

  assign bus.SEL         = sel_q;
  assign bus.CAT         = cat_q;
  assign bus.blank       = blank_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (one blank cycle / no blanking)
// compared each cycle to a slot-based model, plus literal scan sequences.
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 8;

  logic          slow_clock = 1'b1;
  logic          reset;
  logic          enable;
  logic [DW-1:0] dwell;
  logic [ND-1:0] digit_en;

  int checks = 0;
  int errors = 0;

  always #5 slow_clock = ~slow_clock;

  display_scan_ctrl_if #(.NUM_DIGITS(ND), .DWELL_W(DW)) bus0 ();
  display_scan_ctrl_if #(.NUM_DIGITS(ND), .DWELL_W(DW)) bus1 ();

  assign bus0.enable   = enable;
  assign bus0.dwell    = dwell;
  assign bus0.digit_en = digit_en;
  assign bus1.enable   = enable;
  assign bus1.dwell    = dwell;
  assign bus1.digit_en = digit_en;

  display_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_W(DW), .BLANK_CYCLES(1)) dut0 (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus0)
  );

  display_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_W(DW), .BLANK_CYCLES(0)) dut1 (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus1)
  );

  logic [1:0]    sel_o   [2];
  logic [ND-1:0] cat_o   [2];
  logic          blank_o [2];
  logic          fs_o    [2];

  assign sel_o[0]   = bus0.SEL;
  assign cat_o[0]   = bus0.CAT;
  assign blank_o[0] = bus0.blank;
  assign fs_o[0]    = bus0.frame_start;
  assign sel_o[1]   = bus1.SEL;
  assign cat_o[1]   = bus1.CAT;
  assign blank_o[1] = bus1.blank;
  assign fs_o[1]    = bus1.frame_start;

  // Model: each digit owns a slot of dwell+1 lit positions followed by the blank positions.
  bit m_valid  [2];
  bit m_active [2];
  int m_sel    [2];
  int m_pos    [2];
  int m_dw     [2];
  bit m_gate   [2];
  bit m_fs     [2];

  function automatic int blank_len(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  function automatic int lowest_enabled(input logic [ND-1:0] m);
    for (int i = 0; i < ND; i++)
      if (m[2'(i)]) return i;
    return 0;
  endfunction

  function automatic int next_enabled(input int cur, input logic [ND-1:0] m);
    for (int k = 1; k <= ND; k++)
      if (m[2'((cur + k) % ND)]) return (cur + k) % ND;
    return cur;
  endfunction

  function automatic logic [ND-1:0] exp_cat(input int u);
    if (m_active[u] && m_pos[u] <= m_dw[u] && m_gate[u])
      return ND'(1) << (ND - 1 - m_sel[u]);
    return '0;
  endfunction

  task automatic start_slot(input int u, input int s, input bit fs);
    m_active[u] = 1'b1;
    m_sel[u]    = s;
    m_pos[u]    = 0;
    m_dw[u]     = int'(dwell);
    m_gate[u]   = 1'b1;
    m_fs[u]     = fs;
  endtask

  task automatic model_step(input int u);
    int nx;
    if (!reset) begin
      m_valid[u]  = 1'b1;
      m_active[u] = 1'b0;
      m_sel[u]    = 0;
      m_fs[u]     = 1'b0;
    end else if (!enable) begin
      m_active[u] = 1'b0;
      m_fs[u]     = 1'b0;
    end else if (!m_active[u]) begin
      m_fs[u] = 1'b0;
      if (digit_en != '0) start_slot(u, lowest_enabled(digit_en), 1'b1);
    end else begin
      m_fs[u] = 1'b0;
      m_pos[u]++;
      if (m_pos[u] == m_dw[u] + 1 + blank_len(u)) begin
        if (digit_en == '0) begin
          m_active[u] = 1'b0;
        end else begin
          nx = next_enabled(m_sel[u], digit_en);
          start_slot(u, nx, nx <= m_sel[u]);
        end
      end else begin
        m_gate[u] = digit_en[2'(m_sel[u])];
      end
    end
  endtask

  always @(negedge slow_clock) begin
    for (int u = 0; u < 2; u++) model_step(u);
  end

  always @(posedge slow_clock) begin
    for (int u = 0; u < 2; u++) begin
      if (m_valid[u]) begin
        checks++;
        if (sel_o[u] !== 2'(m_sel[u]) || cat_o[u] !== exp_cat(u) ||
            blank_o[u] !== (exp_cat(u) == '0) || fs_o[u] !== m_fs[u]) begin
          errors++;
          $display("[TB] FAIL model_dut%0d t=%0t got SEL=%0d CAT=%b blank=%b frame_start=%b want SEL=%0d CAT=%b blank=%b frame_start=%b",
                   u, $time, sel_o[u], cat_o[u], blank_o[u], fs_o[u],
                   m_sel[u], exp_cat(u), exp_cat(u) == '0, m_fs[u]);
        end
      end
    end
  end

  task automatic check_output(input string name, input int u, input logic [1:0] s,
                              input logic [ND-1:0] c, input logic f);
    checks++;
    if (sel_o[u] !== s || cat_o[u] !== c || blank_o[u] !== (c == '0) || fs_o[u] !== f) begin
      errors++;
      $display("[TB] FAIL %s dut%0d t=%0t got SEL=%0d CAT=%b blank=%b frame_start=%b want SEL=%0d CAT=%b blank=%b frame_start=%b",
               name, u, $time, sel_o[u], cat_o[u], blank_o[u], fs_o[u], s, c, c == '0, f);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic [DW-1:0] d,
                                input logic [ND-1:0] m);
    reset    = r;
    enable   = e;
    dwell    = d;
    digit_en = m;
  endtask

  logic [ND-1:0] scan_tbl  [16] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000,
                                    4'b0100, 4'b0100, 4'b0100, 4'b0000,
                                    4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                    4'b0001, 4'b0001, 4'b0001, 4'b0000};
  logic [ND-1:0] dwell_tbl [11] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000,
                                    4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                    4'b0100, 4'b0100, 4'b0000};

  initial begin
    int r;
    apply_stimulus(1'b0, 1'b1, 8'd2, 4'b1111);
    repeat (3) @(posedge slow_clock);
    check_output("reset_state", 0, 2'd0, 4'b0000, 1'b0);
    check_output("reset_state", 1, 2'd0, 4'b0000, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(posedge slow_clock);
      check_output("scan_dwell2_blank1", 0, 2'((i % 16) / 4), scan_tbl[i % 16], (i % 16) == 0);
    end

    apply_stimulus(1'b1, 1'b0, 8'd0, 4'b1010);
    @(posedge slow_clock);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge slow_clock);
      check_output("alternate_1_3", 1, (i % 2 == 1) ? 2'd3 : 2'd1,
                   (i % 2 == 1) ? 4'b0001 : 4'b0100, (i % 2) == 0);
    end

    apply_stimulus(1'b1, 1'b0, 8'd2, 4'b1111);
    @(posedge slow_clock);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge slow_clock);
      check_output("scan_to_digit2", 0, 2'(i / 4), scan_tbl[i], i == 0);
    end
    enable = 1'b0;
    @(posedge slow_clock);
    check_output("enable_drop", 0, 2'd2, 4'b0000, 1'b0);
    enable = 1'b1;
    @(posedge slow_clock);
    check_output("re_enable", 0, 2'd0, 4'b1000, 1'b1);
    dwell = 8'd5;
    for (int i = 1; i < 11; i++) begin
      @(posedge slow_clock);
      check_output("dwell_change", 0, (i < 4) ? 2'd0 : 2'd1, dwell_tbl[i], 1'b0);
    end

    apply_stimulus(1'b1, 1'b0, 8'd2, 4'b1111);
    @(posedge slow_clock);
    enable = 1'b1;
    @(posedge slow_clock);
    check_output("clear_start", 0, 2'd0, 4'b1000, 1'b1);
    digit_en = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(posedge slow_clock);
      check_output("cleared_dark", 0, 2'd0, 4'b0000, 1'b0);
    end
    digit_en = 4'b0010;
    @(posedge slow_clock);
    check_output("clear_resume", 0, 2'd1, 4'b0100, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      @(posedge slow_clock);
      reset = ($urandom_range(0, 99) >= 2);
      r = $urandom_range(0, 99);
      if (r < 4) enable = 1'b0;
      else if (r < 20) enable = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 3) digit_en = 4'(1 << $urandom_range(0, 3));
      else if (r < 8) digit_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 10) dwell = 8'($urandom_range(0, 4));
    end

    @(posedge slow_clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
